// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
//   Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/SRL/SLL/SRA) complete the cycle
//   after start; MULU (shift-add) and DIVU (restoring) iterate one bit per
//   cycle. Every output is registered.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i, op_i       request (sampled only in IDLE) and op code
//   a_i, b_i, shamt_i   operands and shift amount
//   busy_o, done_o      not-IDLE indicator, one-cycle completion pulse
//   result_o, hi_o      primary result, product-high / remainder
//   zout_o, nout_o      result zero / result sign
//   blez_o              captured a <= 0 (signed)
//   dz_o, bad_op_o      divide-by-zero, undefined op code
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zout_o,
  output logic             nout_o,
  output logic             blez_o,
  output logic             dz_o,
  output logic             bad_op_o
);

  localparam int CW = SHW + 1;  // count must hold WIDTH itself

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDA = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // MUL: multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] b_q, b_d;      // MUL: multiplier -> product low; DIV: divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // MUL: product high; DIV: partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             blez_cap_q, blez_cap_d;
  logic             busy_q, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zout_q, zout_d, nout_q, nout_d, blez_q, blez_d;
  logic             dz_q, dz_d, bad_q, bad_d;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   sub_x;   // sign-extended WIDTH+1-bit a - b
  logic [WIDTH-1:0] sc_res;
  logic             sc_bad;
  logic             a_blez;

  assign sub_x  = {a_i[WIDTH-1], a_i} + ~{b_i[WIDTH-1], b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign a_blez = a_i[WIDTH-1] | (a_i == '0);

  always_comb begin
    sc_res = '0;
    sc_bad = 1'b0;
    unique case (op_i)
      OP_AND:          sc_res = a_i & b_i;
      OP_OR:           sc_res = a_i | b_i;
      OP_XOR:          sc_res = a_i ^ b_i;
      OP_ADD, OP_ADDA: sc_res = a_i + b_i;
      OP_SUB:          sc_res = sub_x[WIDTH-1:0];
      // sign of the widened difference is correct even when a-b overflows
      OP_SLT:          sc_res = {{(WIDTH-1){1'b0}}, sub_x[WIDTH]};
      OP_SRL:          sc_res = b_i >> shamt_i;
      OP_SLL:          sc_res = b_i << shamt_i;
      OP_SRA:          sc_res = $unsigned($signed(b_i) >>> shamt_i);
      OP_MULU, OP_DIVU: sc_res = '0;  // handled by the iterative path
      default:         sc_bad = 1'b1;
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_quo;

  assign mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_sh  = {acc_q, a_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, b_q};
  // when div_ge holds the difference is below the divisor, so WIDTH bits suffice
  assign div_rem = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
  assign div_quo = {a_q[WIDTH-2:0], div_ge};

  // ---------------- control ----------------
  logic             fin;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_blez, fin_dz, fin_bad;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    blez_cap_d = blez_cap_q;
    done_d     = 1'b0;
    result_d   = result_q;
    hi_d       = hi_q;
    zout_d     = zout_q;
    nout_d     = nout_q;
    blez_d     = blez_q;
    dz_d       = dz_q;
    bad_d      = bad_q;
    fin        = 1'b0;
    fin_res    = '0;
    fin_hi     = '0;
    fin_blez   = 1'b0;
    fin_dz     = 1'b0;
    fin_bad    = 1'b0;

    unique case (state_q)
      IDLE: if (start_i) begin
        if (op_i == OP_MULU || (op_i == OP_DIVU && b_i != '0)) begin
          a_d        = a_i;
          b_d        = b_i;
          acc_d      = '0;
          cnt_d      = CW'(WIDTH);
          blez_cap_d = a_blez;
          state_d    = (op_i == OP_MULU) ? MUL : DIV;
        end else if (op_i == OP_DIVU) begin
          fin      = 1'b1;
          fin_res  = '1;
          fin_hi   = a_i;
          fin_blez = a_blez;
          fin_dz   = 1'b1;
        end else begin
          fin      = 1'b1;
          fin_res  = sc_res;
          fin_blez = a_blez;
          fin_bad  = sc_bad;
        end
      end
      MUL: begin
        acc_d = mul_sum[WIDTH:1];
        b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin      = 1'b1;
          fin_res  = {mul_sum[0], b_q[WIDTH-1:1]};
          fin_hi   = mul_sum[WIDTH:1];
          fin_blez = blez_cap_q;
          state_d  = IDLE;
        end
      end
      DIV: begin
        acc_d = div_rem;
        a_d   = div_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin      = 1'b1;
          fin_res  = div_quo;
          fin_hi   = div_rem;
          fin_blez = blez_cap_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      done_d   = 1'b1;
      result_d = fin_res;
      hi_d     = fin_hi;
      zout_d   = (fin_res == '0);
      nout_d   = fin_res[WIDTH-1];
      blez_d   = fin_blez;
      dz_d     = fin_dz;
      bad_d    = fin_bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      blez_cap_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      zout_q     <= 1'b1;
      nout_q     <= 1'b0;
      blez_q     <= 1'b0;
      dz_q       <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      blez_cap_q <= blez_cap_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      zout_q     <= zout_d;
      nout_q     <= nout_d;
      blez_q     <= blez_d;
      dz_q       <= dz_d;
      bad_q      <= bad_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zout_o   = zout_q;
  assign nout_o   = nout_q;
  assign blez_o   = blez_q;
  assign dz_o     = dz_q;
  assign bad_op_o = bad_q;

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: directed vectors; expected responses are queued at
// issue time and a monitor pops/compares on every done pulse.
module tb_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic          busy, done, zout, nout, blez, dz, bad_op;
  logic [W-1:0]  result, hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [4:0]   fl;   // {zout, nout, blez, dz, bad_op}
    string        nm;
  } exp_t;
  exp_t sb[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .shamt_i(shamt), .busy_o(busy), .done_o(done), .result_o(result), .hi_o(hi),
    .zout_o(zout), .nout_o(nout), .blez_o(blez), .dz_o(dz), .bad_op_o(bad_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done result %h hi %h", result, hi);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.nm, {11'd0, result, hi, zout, nout, blez, dz, bad_op},
                  {11'd0, e.r, e.h, e.fl});
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},   80'(busy),   80'(0));
    chk({tag, "_done"},   80'(done),   80'(0));
    chk({tag, "_result"}, 80'(result), 80'(0));
    chk({tag, "_hi"},     80'(hi),     80'(0));
    chk({tag, "_flags"},  80'({zout, nout, blez, dz, bad_op}), 80'(5'b10000));
  endtask

  // Issue one op at a negedge, queue its expectation, wait for done.
  // mid=1 pulses a stray start (ADD) in the 5th busy cycle, which must be ignored.
  task automatic run(input string nm, input logic [3:0] o, input logic [W-1:0] va,
                     input logic [W-1:0] vb, input logic [4:0] sh,
                     input logic [W-1:0] er, input logic [W-1:0] eh,
                     input logic [4:0] efl, input int lat, input bit mid);
    int n;
    bit busy_bad;
    exp_t e;
    e.r = er; e.h = eh; e.fl = efl; e.nm = nm;
    sb.push_back(e);
    op = o; a = va; b = vb; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb;          // operands must already be latched
    n = 1;
    busy_bad = 1'b0;
    while (!done && n < 200) begin
      if (!busy) busy_bad = 1'b1;
      if (mid && n == 5) begin op = 4'b0010; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 80'(n), 80'(lat));
    if (lat > 1) chk({nm, "_busy_during"}, 80'(busy_bad), 80'(0));
    chk({nm, "_busy_at_done"}, 80'(busy), 80'(0));
  endtask

  initial begin
    int dseen;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("reset");

    //   name      op       a             b             sh     result        hi            {z,n,blez,dz,bad} lat
    run("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0,        5'b01000, 1,  0);
    run("sub_eq",  4'b0110, 32'd5,        32'd5,        5'd0,  32'h0,        32'h0,        5'b10000, 1,  0);
    run("slt_neg", 4'b0111, 32'h80000000, 32'h00000001, 5'd0,  32'h1,        32'h0,        5'b00100, 1,  0);
    run("slt_pos", 4'b0111, 32'h00000001, 32'h80000000, 5'd0,  32'h0,        32'h0,        5'b10000, 1,  0);
    run("srl",     4'b0100, 32'h1,        32'hF0000000, 5'd4,  32'h0F000000, 32'h0,        5'b00000, 1,  0);
    run("sra",     4'b1000, 32'h1,        32'hF0000000, 5'd4,  32'hFF000000, 32'h0,        5'b01000, 1,  0);
    run("sll31",   4'b0101, 32'h1,        32'h00000001, 5'd31, 32'h80000000, 32'h0,        5'b01000, 1,  0);
    run("xor",     4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 32'h0,        5'b00100, 1,  0);
    run("or",      4'b0001, 32'h0000000F, 32'h000000F0, 5'd0,  32'h000000FF, 32'h0,        5'b00000, 1,  0);
    run("adda",    4'b0011, 32'h00001000, 32'h00000024, 5'd0,  32'h00001024, 32'h0,        5'b00000, 1,  0);
    run("mulu_max",4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 32'hFFFFFFFE, 5'b00100, 33, 1);
    run("mulu_sm", 4'b1010, 32'h12345678, 32'h00000010, 5'd0,  32'h23456780, 32'h00000001, 5'b00000, 33, 0);
    run("divu",    4'b1011, 32'd100,      32'd7,        5'd0,  32'd14,       32'd2,        5'b00000, 33, 0);
    run("divu_big",4'b1011, 32'hFFFFFFFF, 32'h00000010, 5'd0,  32'h0FFFFFFF, 32'h0000000F, 5'b00100, 33, 0);
    run("divu_z",  4'b1011, 32'd100,      32'd0,        5'd0,  32'hFFFFFFFF, 32'd100,      5'b01010, 1,  0);
    run("add_clr", 4'b0010, 32'd1,        32'd1,        5'd0,  32'd2,        32'h0,        5'b00000, 1,  0);

    // Abort a MULU with reset at cycle 10: immediate reset values, no done.
    op = 4'b1010; a = 32'hDEADBEEF; b = 32'h12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dseen = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("abort_no_done", 80'(dseen), 80'(0));

    run("add_post",4'b0010, 32'd2,        32'd3,        5'd0,  32'd5,        32'h0,        5'b00000, 1,  0);
    run("bad_op",  4'b1111, 32'd4,        32'd9,        5'd0,  32'h0,        32'h0,        5'b10001, 1,  0);
    run("and_blez",4'b0000, 32'h0,        32'hFFFFFFFF, 5'd0,  32'h0,        32'h0,        5'b10100, 1,  0);

    // Outputs hold between completions.
    repeat (3) @(negedge clk);
    chk("hold_result", 80'({result, hi, zout, blez}), 80'({32'h0, 32'h0, 1'b1, 1'b1}));
    chk("queue_empty", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
